food_placer: RTL and testbench

FOOD_PLACER -- requirements
Module: food_placer

---
 rtl/snek_pkg.sv | 20 ++
 rtl/food_placer.sv | 159 +++++++++++++++
 tb/tb_food_placer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/snek_pkg.sv
// snek_pkg: shared board types, grid size and the food placer state encoding.
// SCAN is only part of the encoding when FOOD_SCAN_FALLBACK_EN is defined.
package snek_pkg;

    localparam int GRID_DIM = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_X,
        GET_Y,
        QUERY,
        WAIT_RESP
`ifdef FOOD_SCAN_FALLBACK_EN
        , SCAN
`endif
    } fp_state_t;

endpackage

// File: rtl/food_placer.sv
// food_placer: picks random free cells for food via an occupancy query handshake.
// Define FOOD_SCAN_FALLBACK_EN to scan the board in order once random tries run out.
module food_placer
    import snek_pkg::*;
#(
    parameter int MAX_TRIES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rnd_in,
    input  logic       spawn_req,
    output logic       occ_query_valid,
    output coord_t     occ_x,
    output coord_t     occ_y,
    input  logic       occ_resp_valid,
    input  logic       occ_hit,
    output coord_t     food_x,
    output coord_t     food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_fail
);

    localparam logic [7:0] MAX_T = 8'(MAX_TRIES);

    fp_state_t  state, state_nx;
    coord_t     cand_x, cand_x_nx, cand_y, cand_y_nx;
    coord_t     occ_x_nx, occ_y_nx, food_x_nx, food_y_nx;
    logic [7:0] tries, tries_nx, tries_inc;
    logic       occ_q_nx, food_valid_nx, fail_nx;

    // saturate so the counter can never wrap even with MAX_TRIES=255
    assign tries_inc = (tries == 8'hFF) ? tries : tries + 8'd1;
    assign busy      = (state != IDLE);

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam logic [8:0] SCAN_CELLS = 9'(GRID_DIM * GRID_DIM);

    logic [8:0] scan_cnt, scan_cnt_nx;
    logic [7:0] scan_nxt;
    logic       scanning;

    // {y,x} as one 8-bit number makes x carry into y and y wrap naturally
    assign scan_nxt = {cand_y, cand_x} + 8'd1;
    assign scanning = (tries == MAX_T);
`endif

    always_comb begin
        state_nx      = state;
        cand_x_nx     = cand_x;
        cand_y_nx     = cand_y;
        tries_nx      = tries;
        occ_q_nx      = 1'b0;
        occ_x_nx      = occ_x;
        occ_y_nx      = occ_y;
        food_x_nx     = food_x;
        food_y_nx     = food_y;
        food_valid_nx = food_valid;
        fail_nx       = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_cnt_nx   = scan_cnt;
`endif
        case (state)
            IDLE: begin
                if (spawn_req) begin
                    food_valid_nx = 1'b0;
                    tries_nx      = 8'd0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    scan_cnt_nx   = 9'd0;
`endif
                    state_nx      = GET_X;
                end
            end
            GET_X: begin
                cand_x_nx = rnd_in;
                state_nx  = GET_Y;
            end
            GET_Y: begin
                cand_y_nx = rnd_in;
                occ_q_nx  = 1'b1;
                occ_x_nx  = cand_x;
                occ_y_nx  = rnd_in;
                state_nx  = QUERY;
            end
            QUERY: state_nx = WAIT_RESP;
            WAIT_RESP: begin
                if (occ_resp_valid) begin
                    if (!occ_hit) begin
                        food_x_nx     = cand_x;
                        food_y_nx     = cand_y;
                        food_valid_nx = 1'b1;
                        state_nx      = IDLE;
                    end
`ifdef FOOD_SCAN_FALLBACK_EN
                    else if (scanning) begin
                        fail_nx  = (scan_cnt == SCAN_CELLS);
                        state_nx = (scan_cnt == SCAN_CELLS) ? IDLE : SCAN;
                    end else begin
                        tries_nx = tries_inc;
                        state_nx = (tries_inc < MAX_T) ? GET_X : SCAN;
                    end
`else
                    else begin
                        tries_nx = tries_inc;
                        fail_nx  = (tries_inc >= MAX_T);
                        state_nx = (tries_inc < MAX_T) ? GET_X : IDLE;
                    end
`endif
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            SCAN: begin
                {cand_y_nx, cand_x_nx} = scan_nxt;
                occ_q_nx    = 1'b1;
                occ_x_nx    = scan_nxt[3:0];
                occ_y_nx    = scan_nxt[7:4];
                scan_cnt_nx = scan_cnt + 9'd1;
                state_nx    = QUERY;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cand_x          <= '0;
            cand_y          <= '0;
            tries           <= '0;
            occ_query_valid <= 1'b0;
            occ_x           <= '0;
            occ_y           <= '0;
            food_x          <= '0;
            food_y          <= '0;
            food_valid      <= 1'b0;
            spawn_fail      <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_cnt        <= '0;
`endif
        end else begin
            state           <= state_nx;
            cand_x          <= cand_x_nx;
            cand_y          <= cand_y_nx;
            tries           <= tries_nx;
            occ_query_valid <= occ_q_nx;
            occ_x           <= occ_x_nx;
            occ_y           <= occ_y_nx;
            food_x          <= food_x_nx;
            food_y          <= food_y_nx;
            food_valid      <= food_valid_nx;
            spawn_fail      <= fail_nx;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_cnt        <= scan_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed spawn scenarios against hand-computed cells and latencies.
module tb_food_placer;
    import snek_pkg::*;

    localparam int MT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rnd_in = 4'd0;
    logic       spawn_req = 1'b0;
    logic       occ_resp_valid = 1'b0;
    logic       occ_hit = 1'b0;
    logic       occ_query_valid, food_valid, busy, spawn_fail;
    coord_t     occ_x, occ_y, food_x, food_y;

    food_placer #(.MAX_TRIES(MT)) dut (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .spawn_req(spawn_req),
        .occ_query_valid(occ_query_valid), .occ_x(occ_x), .occ_y(occ_y),
        .occ_resp_valid(occ_resp_valid), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    int         errors = 0, checks = 0;
    logic [3:0] rnd_tab[16];
    int         free_idx, nq, nfail, lat;
    logic [3:0] qx[8], qy[8];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rnd(input logic [3:0] v);
        for (int i = 0; i < 16; i++) rnd_tab[i] = v;
    endtask

    // one spawn: query free_idx gets occ_hit=0, all others 1; responses come one cycle after each query
    task automatic run(input int budget, input int extra_req, input logic stray);
        logic pend;
        pend = 1'b0;
        nq = 0;
        nfail = 0;
        lat = -1;
        spawn_req = 1'b1;
        occ_resp_valid = stray;
        occ_hit = 1'b0;
        tick;
        spawn_req = 1'b0;
        occ_resp_valid = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            occ_resp_valid = pend;
            occ_hit = pend && (nq - 1 != free_idx);
            if (pend && nq <= 8) begin
                check("occ_x_hold", occ_x, qx[nq-1]);
                check("occ_y_hold", occ_y, qy[nq-1]);
            end
            pend = occ_query_valid;
            if (occ_query_valid) begin
                if (nq < 8) begin
                    qx[nq] = occ_x;
                    qy[nq] = occ_y;
                end
                nq++;
            end
            if (spawn_fail) nfail++;
            if (!busy) begin
                lat = c;
                break;
            end
            spawn_req = (c == extra_req);
            rnd_in = rnd_tab[c % 16];
            tick;
        end
        occ_resp_valid = 1'b0;
        occ_hit = 1'b0;
        spawn_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        check("rst_flags", {food_valid, occ_query_valid, spawn_fail, busy}, 4'b0);
        check("rst_coords", {occ_x, occ_y, food_x, food_y}, 16'h0);
        reset = 1'b1;
        tick;

        fill_rnd(4'd6);
        rnd_tab[1] = 4'd3;
        rnd_tab[2] = 4'd9;
        free_idx = 0;
        run(40, 0, 1'b0);
        check("free_lat", lat, 5);
        check("free_nq", nq, 1);
        check("free_q0", {qx[0], qy[0]}, 8'h39);
        check("free_food", {food_valid, food_x, food_y}, 9'h139);
        check("free_nfail", nfail, 0);
        tick;
        check("free_hold", {busy, food_valid}, 2'b01);

        fill_rnd(4'd6);
        rnd_tab[1] = 4'd2;  rnd_tab[2] = 4'd7;
        rnd_tab[5] = 4'd12; rnd_tab[6] = 4'd4;
        rnd_tab[9] = 4'd15; rnd_tab[10] = 4'd0;
        free_idx = 2;
        run(60, 0, 1'b0);
        check("retry_lat", lat, 13);
        check("retry_nq", nq, 3);
        check("retry_q0", {qx[0], qy[0]}, 8'h27);
        check("retry_q1", {qx[1], qy[1]}, 8'hC4);
        check("retry_q2", {qx[2], qy[2]}, 8'hF0);
        check("retry_food", {food_valid, food_x, food_y}, 9'h1F0);
        check("retry_nfail", nfail, 0);

        fill_rnd(4'd6);
        rnd_tab[1] = 4'd1;  rnd_tab[2] = 4'd1;
        rnd_tab[5] = 4'd2;  rnd_tab[6] = 4'd2;
        rnd_tab[9] = 4'd15; rnd_tab[10] = 4'd15;
        free_idx = -1;
`ifdef FOOD_SCAN_FALLBACK_EN
        run(2000, 0, 1'b0);
        check("full_lat", lat, 781);
        check("full_nq", nq, 259);
        check("full_nfail", nfail, 1);
        check("full_scan_q3", {qx[3], qy[3]}, 8'h00);
        check("full_scan_q4", {qx[4], qy[4]}, 8'h10);
        check("full_state", {busy, food_valid}, 2'b00);
        tick;
        check("full_pulse", spawn_fail, 1'b0);
        free_idx = 4;
        run(100, 0, 1'b0);
        check("scan_lat", lat, 19);
        check("scan_nq", nq, 5);
        check("scan_q3", {qx[3], qy[3]}, 8'h00);
        check("scan_q4", {qx[4], qy[4]}, 8'h10);
        check("scan_food", {food_valid, food_x, food_y}, 9'h110);
        check("scan_nfail", nfail, 0);
`else
        run(60, 0, 1'b0);
        check("exh_lat", lat, 13);
        check("exh_nq", nq, 3);
        check("exh_nfail", nfail, 1);
        check("exh_state", {busy, food_valid}, 2'b00);
        tick;
        check("exh_pulse", spawn_fail, 1'b0);
`endif

        fill_rnd(4'd6);
        rnd_tab[1] = 4'd5;
        rnd_tab[2] = 4'd11;
        free_idx = 0;
        run(40, 2, 1'b0);
        check("busyreq_lat", lat, 5);
        check("busyreq_food", {food_valid, food_x, food_y}, 9'h15B);
        tick;
        tick;
        check("busyreq_noqueue", busy, 1'b0);

        rnd_tab[1] = 4'd4;
        rnd_tab[2] = 4'd13;
        run(40, 0, 1'b1);
        check("stray_lat", lat, 5);
        check("stray_nq", nq, 1);
        check("stray_food", {food_valid, food_x, food_y}, 9'h14D);

        spawn_req = 1'b1;
        tick;
        spawn_req = 1'b0;
        rnd_in = 4'd7;
        tick;
        rnd_in = 4'd8;
        tick;
        check("rstw_query", {occ_query_valid, occ_x, occ_y}, 9'h178);
        tick;
        check("rstw_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rstw_async_flags", {food_valid, occ_query_valid, spawn_fail, busy}, 4'b0);
        check("rstw_async_coords", {occ_x, occ_y, food_x, food_y}, 16'h0);
        tick;
        reset = 1'b1;
        occ_resp_valid = 1'b1;
        occ_hit = 1'b0;
        tick;
        occ_resp_valid = 1'b0;
        tick;
        check("rstw_late_resp", {food_valid, busy, occ_query_valid}, 3'b000);
        check("rstw_food_xy", {food_x, food_y}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
